// File: rtl/repadd_mult_ctrl_if.sv
// ---------------------------------------------------------------------------
// repadd_mult_ctrl_if
//   Handshake / strobe bundle between the repeated-addition multiplier
//   controller, the system sequencer and the multiplier datapath.
//   Parameter W : operand width (width of iter_cnt).
//   Signals:
//     start, abort   sequencer -> controller
//     eqz            datapath  -> controller (B register == 0)
//     ld_a, ld_b, clr_p, add_en, dec_b   controller -> datapath strobes
//     busy, done, err, iter_cnt          controller -> sequencer status
//   Modports: master = controller side, slave = sequencer/datapath side.
// ---------------------------------------------------------------------------
interface repadd_mult_ctrl_if #(parameter int W = 8);
  logic         start;
  logic         abort;
  logic         eqz;
  logic         ld_a;
  logic         ld_b;
  logic         clr_p;
  logic         add_en;
  logic         dec_b;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] iter_cnt;

  modport master (
    input  start, abort, eqz,
    output ld_a, ld_b, clr_p, add_en, dec_b, busy, done, err, iter_cnt
  );

  modport slave (
    output start, abort, eqz,
    input  ld_a, ld_b, clr_p, add_en, dec_b, busy, done, err, iter_cnt
  );
endinterface

// File: rtl/repadd_mult_ctrl.sv
// ---------------------------------------------------------------------------
// repadd_mult_ctrl
//   Control path for a repeated-addition multiplier (P = A * B by adding A
//   to P while decrementing B until B == 0). Sequences load/clear/add/dec
//   strobes from a start/done handshake using the datapath eqz flag.
//   Parameters:
//     W       operand width
//     TMO_CYC watchdog limit in busy cycles (used with TIMEOUT_EN)
//   Ports:
//     clk     rising-edge clock
//     arstn   asynchronous active-low reset
//     bus     repadd_mult_ctrl_if.master (start/abort/eqz in, strobes and
//             busy/done/err/iter_cnt out)
//   Optional feature macro: TIMEOUT_EN builds the busy-cycle watchdog and
//   the ERR exit; without it err is tied low and ERR is unreachable.
//   All strobes are Moore outputs decoded from the state register, so an
//   asserted reset drops them without waiting for a clock edge.
// ---------------------------------------------------------------------------
module repadd_mult_ctrl #(
  parameter int W       = 8,
  parameter int TMO_CYC = 600
) (
  input  logic                   clk,
  input  logic                   arstn,
  repadd_mult_ctrl_if.master     bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_CHECK  = 3'd3,
    S_ADD    = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t state, state_nxt;
  logic   tmo_hit;

  // The watchdog must at least be able to reach the CHECK/ADD loop.
  if (TMO_CYC < 4) begin : g_tmo_chk
    $error("repadd_mult_ctrl: TMO_CYC must be at least 4");
  end

`ifdef TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  // Counts busy cycles: 0 in LOAD_A, so it reads TMO_CYC in the ERR cycle.
  // Saturates so the ERR cycle cannot wrap a narrow counter.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)                          tmo_cnt <= '0;
    else if (state == S_IDLE)            tmo_cnt <= '0;
    else if (tmo_cnt != TW'(TMO_CYC))    tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (tmo_cnt == TW'(TMO_CYC - 1)) &&
                   ((state == S_CHECK) || (state == S_ADD));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.ld_a    = 1'b0;
    bus.ld_b    = 1'b0;
    bus.clr_p   = 1'b0;
    bus.add_en  = 1'b0;
    bus.dec_b   = 1'b0;
    bus.busy    = (state != S_IDLE);
    bus.done    = 1'b0;
    bus.err     = 1'b0;

    unique case (state)
      S_IDLE:   if (bus.start) state_nxt = S_LOAD_A;
      S_LOAD_A: begin
        bus.ld_a  = 1'b1;
        state_nxt = S_LOAD_B;
      end
      S_LOAD_B: begin
        bus.ld_b  = 1'b1;
        bus.clr_p = 1'b1;
        state_nxt = S_CHECK;
      end
      S_CHECK: begin
        // B was loaded at the previous edge, so eqz is valid here.
        if (tmo_hit)      state_nxt = S_ERR;
        else if (bus.eqz) state_nxt = S_DONE;
        else              state_nxt = S_ADD;
      end
      S_ADD: begin
        bus.add_en = 1'b1;
        bus.dec_b  = 1'b1;
        state_nxt  = tmo_hit ? S_ERR : S_CHECK;
      end
      S_DONE: begin
        bus.done  = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
`ifdef TIMEOUT_EN
        bus.err   = 1'b1;
`endif
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Abort overrides every other transition out of a busy state.
    if ((state != S_IDLE) && bus.abort) state_nxt = S_IDLE;
  end

  // iter_cnt is updated on entry to LOAD_B / ADD so that during the k-th ADD
  // it already reads k; an abort there therefore reports that ADD as done.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)
      bus.iter_cnt <= '0;
    else if ((state == S_LOAD_A) && (state_nxt == S_LOAD_B))
      bus.iter_cnt <= '0;
    else if ((state == S_CHECK) && (state_nxt == S_ADD))
      bus.iter_cnt <= bus.iter_cnt + 1'b1;
  end

endmodule

// File: tb/tb_repadd_mult_ctrl.sv
// ---------------------------------------------------------------------------
// tb_repadd_mult_ctrl
//   Bench for repadd_mult_ctrl with a small multiplier datapath and a
//   cycle-index reference model derived from the operation timeline
//   (LOAD_A at cycle 1, LOAD_B at 2, CHECK/ADD pairs, DONE at 2n+4).
//   Build with +define+TIMEOUT_EN to exercise the watchdog (TMO_CYC=20).
// ---------------------------------------------------------------------------
module tb_repadd_mult_ctrl;
  localparam int W   = 8;
  localparam int TMO = 20;
  localparam int NSTUCK = 1 << 20;

  logic clk   = 1'b0;
  logic arstn = 1'b1;
  always #5 clk = ~clk;

  repadd_mult_ctrl_if #(.W(W)) bus();

  repadd_mult_ctrl #(.W(W), .TMO_CYC(TMO)) dut (
    .clk   (clk),
    .arstn (arstn),
    .bus   (bus)
  );

  // Datapath model: shared input bus in_a/in_b, registers A, B, P.
  logic [W-1:0]   in_a = '0, in_b = '0, ra = '0, rb = '0;
  logic [2*W-1:0] rp = '0;
  logic           eqz_stuck = 1'b0;

  always @(posedge clk) begin
    if (bus.ld_a)   ra <= in_a;
    if (bus.ld_b)   rb <= in_b;
    if (bus.clr_p)  rp <= '0;
    if (bus.add_en) rp <= rp + {{W{1'b0}}, ra};
    if (bus.dec_b)  rb <= rb - 1'b1;
  end
  assign bus.eqz = !eqz_stuck && (rb == '0);

  // Reference model: m_c = cycle index inside the operation (0 = idle).
  int           m_c = 0, m_n = 0;
  logic [W-1:0] m_iter = '0;

  int n_chk = 0, n_pass = 0;
  int done_c, err_c, add_cnt;
  bit done_seen, err_seen;

  // 0 idle, 1 LOAD_A, 2 LOAD_B, 3 CHECK, 4 ADD, 5 DONE, 6 ERR
  function automatic int phase(int c, int n);
    if (c == 0) return 0;
    if (c == 1) return 1;
    if (c == 2) return 2;
`ifdef TIMEOUT_EN
    if (TMO <= 2*n + 3 && c == TMO + 1) return 6;
`endif
    if (c == 2*n + 4) return 5;
    return (c % 2 == 1) ? 3 : 4;
  endfunction

  function automatic logic [8+W-1:0] exp_out();
    int p;
    p = phase(m_c, m_n);
    return {p == 1, p == 2, p == 2, p == 4, p == 4, m_c != 0, p == 5, p == 6, m_iter};
  endfunction

  function automatic logic [8+W-1:0] dut_out();
    return {bus.ld_a, bus.ld_b, bus.clr_p, bus.add_en, bus.dec_b,
            bus.busy, bus.done, bus.err, bus.iter_cnt};
  endfunction

  task automatic check(string nm, longint got, longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t, model cycle %0d)", nm, got, exp, $time, m_c);
  endtask

  task automatic model_step();
    int p;
    p = phase(m_c, m_n);
    if (!arstn) begin
      m_c = 0; m_iter = '0;
    end else if (m_c == 0) begin
      if (bus.start) begin
        m_c = 1;
        m_n = eqz_stuck ? NSTUCK : int'(in_b);
      end
    end else if (bus.abort || p == 5 || p == 6) begin
      m_c = 0;
    end else begin
      m_c++;
      p = phase(m_c, m_n);
      if (p == 2)      m_iter = '0;
      else if (p == 4) m_iter = m_iter + 1'b1;
    end
  endtask

  // One clock: compare at the falling edge, then advance the model at the
  // rising edge and return 1 time unit later so the caller can drive inputs.
  task automatic cyc();
    @(negedge clk);
    check("cycle_outputs", dut_out(), exp_out());
    if (bus.done)   begin done_seen = 1; done_c = m_c; end
    if (bus.err)    begin err_seen  = 1; err_c  = m_c; end
    if (bus.add_en) add_cnt++;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run_op(int a, int b, int abort_at, int start_busy_at, int max_c);
    in_a = W'(a); in_b = W'(b);
    done_seen = 0; err_seen = 0; add_cnt = 0; done_c = -1; err_c = -1;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int k = 0; k < max_c && m_c != 0; k++) begin
      bus.abort = (m_c == abort_at);
      bus.start = (m_c == start_busy_at);
      cyc();
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
    if (m_c != 0) check("op_cycle_bound", bus.busy, 0);
    cyc();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    #1 arstn = 1'b0;

    // Reset held for 3 cycles.
    repeat (3) cyc();
    arstn = 1'b1;
    check("reset_outputs", dut_out(), 0);
    cyc();

    // A=5, B=3.
    run_op(5, 3, -1, -1, 100);
    check("b3_done_cycle", done_c, 10);
    check("b3_iter", bus.iter_cnt, 3);
    check("b3_add_pulses", add_cnt, 3);
    check("b3_product", rp, 15);

    // B=0 boundary.
    run_op(9, 0, -1, -1, 100);
    check("b0_done_cycle", done_c, 4);
    check("b0_add_pulses", add_cnt, 0);
    check("b0_iter", bus.iter_cnt, 0);

    // B=255 boundary.
    run_op(3, 255, -1, -1, 700);
`ifdef TIMEOUT_EN
    check("b255_err_cycle", err_c, TMO + 1);
    check("b255_no_done", done_seen, 0);
`else
    check("b255_done_cycle", done_c, 514);
    check("b255_iter", bus.iter_cnt, 255);
    check("b255_product", rp, 765);
`endif

    // Abort in the 2nd ADD of B=4, with a start pulse while busy.
    run_op(7, 4, 6, 5, 100);
    check("abort_no_done", done_seen, 0);
    check("abort_iter", bus.iter_cnt, 2);
    check("abort_idle", bus.busy, 0);

    // eqz stuck at 0.
    eqz_stuck = 1'b1;
    run_op(1, 1, 40, -1, 100);
    eqz_stuck = 1'b0;
`ifdef TIMEOUT_EN
    check("wd_err_cycle", err_c, TMO + 1);
    check("wd_no_done", done_seen, 0);
    check("wd_iter", bus.iter_cnt, 9);
`else
    check("nowd_err", err_seen, 0);
    check("nowd_no_done", done_seen, 0);
    check("nowd_iter_at_abort", bus.iter_cnt, 19);
`endif

    // Async reset mid-ADD of B=6.
    in_a = 8'd4; in_b = 8'd6;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int k = 0; k < 20 && m_c != 8; k++) cyc();
    check("rst_in_add", bus.add_en, 1);
    arstn = 1'b0;
    #1;
    check("async_rst_strobes", dut_out(), 0);
    m_c = 0; m_iter = '0;
    repeat (2) cyc();
    arstn = 1'b1;
    cyc();
    run_op(7, 6, -1, -1, 100);
    check("post_rst_done_cycle", done_c, 16);
    check("post_rst_product", rp, 42);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      int a, b, ab, sb;
      a  = int'($urandom_range(0, 255));
      b  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 60)) : int'($urandom_range(0, 12));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2*b + 4)) : -1;
      sb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2*b + 4)) : -1;
      run_op(a, b, ab, sb, 200);
      if (done_seen) check("rand_product", rp, a * b);
      repeat ($urandom_range(0, 2)) cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
